// File: rtl/uart_recv_control_pkg.sv
// uart_recv_control_pkg: shared state encodings, error codes and frame defaults
package uart_recv_control_pkg;
  typedef enum logic [2:0] {S_HDR = 3'd0, S_CMD = 3'd1, S_PH = 3'd2, S_PL = 3'd3, S_SUM = 3'd4} parse_state_t;
  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} rx_state_t;
  localparam logic [1:0] ERR_STOP = 2'b01;
  localparam logic [1:0] ERR_SUM = 2'b10;
  localparam logic [1:0] ERR_TMO = 2'b11;
  localparam logic [7:0] DEF_FRAME_HDR = 8'hA5;
endpackage

// File: rtl/uart_recv_control_recv.sv
// uart_recv: 8N1 byte deserialiser with input synchroniser and mid-bit sampling
module uart_recv
  import uart_recv_control_pkg::*;
#(
  parameter int CLK_FREQ = 200000000,
  parameter int UART_BPS = 115200
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       uart_rxd,
  output logic [7:0] uart_dout,
  output logic       done_flag,
  output logic       stop_err,
  output logic       rx_busy
);
  localparam int BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int CW = $clog2(BPS_CNT);
  localparam logic [CW-1:0] CNT_MAX = CW'(BPS_CNT - 1);
  localparam logic [CW-1:0] CNT_MID = CW'(BPS_CNT / 2);
  logic s1, s2, s3, armed, fall, mid;
  logic [1:0] warm;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [7:0] sh;
  rx_state_t st;
  // armed only after a genuine high is seen, so a line held low through reset never fakes a start
  assign fall = st == IDLE && armed && s3 && !s2;
  assign mid = cnt == CNT_MID;
  assign rx_busy = st != IDLE;
  // two-flop synchroniser plus edge-detect flop; warm marks when s2 reflects the real pin
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      {s1, s2, s3} <= 3'b111;
      warm <= 2'b00;
    end else begin
      {s1, s2, s3} <= {uart_rxd, s1, s2};
      warm <= {warm[0], 1'b1};
    end
  end
  // bit FSM: baud counter restarts on the start edge, every bit sampled at its midpoint
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      st <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      uart_dout <= '0;
      done_flag <= 1'b0;
      stop_err <= 1'b0;
      armed <= 1'b0;
    end else begin
      done_flag <= 1'b0;
      stop_err <= 1'b0;
      cnt <= (st == IDLE || cnt == CNT_MAX) ? '0 : cnt + 1'b1;
      if (st == IDLE && warm[1] && s2) armed <= 1'b1;
      case (st)
        IDLE: if (fall) st <= START;
        START: if (mid) begin
          st <= s2 ? IDLE : DATA;
          idx <= '0;
        end
        DATA: if (mid) begin
          sh <= {s2, sh[7:1]};
          idx <= idx + 1'b1;
          if (idx == 3'd7) st <= STOP;
        end
        default: if (mid) begin
          st <= IDLE;
          if (s2) begin
            uart_dout <= sh;
            done_flag <= 1'b1;
          end else begin
            stop_err <= 1'b1;
            armed <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: rtl/uart_recv_control.sv
// uart_recv_control: parses 5-byte command frames from the UART into command strobes and errors
module uart_recv_control
  import uart_recv_control_pkg::*;
#(
  parameter int CLK_FREQ = 200000000,
  parameter int UART_BPS = 115200,
  parameter logic [7:0] FRAME_HDR = DEF_FRAME_HDR,
  parameter int TIMEOUT_CLKS = 2000000
) (
  input  logic        in_clk,
  input  logic        in_rst,
  input  logic        in_uart_rxd,
  output logic [7:0]  out_rx_byte,
  output logic        out_rx_byte_valid,
  output logic [7:0]  out_cmd,
  output logic [15:0] out_param,
  output logic        out_cmd_valid,
  output logic        out_err,
  output logic [1:0]  out_err_code,
  output logic        out_busy
);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CLKS);
  logic rx_busy, stop_err, tmo_hit;
  logic [7:0] cmd_r, ph_r, pl_r, sum;
  logic [TW-1:0] tmo;
  parse_state_t ps;
  uart_recv #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS)) u_recv (
    .sys_clk(in_clk),
    .sys_rst_n(in_rst),
    .uart_rxd(in_uart_rxd),
    .uart_dout(out_rx_byte),
    .done_flag(out_rx_byte_valid),
    .stop_err(stop_err),
    .rx_busy(rx_busy)
  );
  assign sum = cmd_r + ph_r + pl_r;
  assign tmo_hit = ps != S_HDR && tmo == TMO_MAX;
  assign out_busy = rx_busy || ps != S_HDR;
  // frame parser; priority is stop error, then byte arrival, then inter-byte timeout
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      ps <= S_HDR;
      tmo <= '0;
      cmd_r <= '0;
      ph_r <= '0;
      pl_r <= '0;
      out_cmd <= '0;
      out_param <= '0;
      out_cmd_valid <= 1'b0;
      out_err <= 1'b0;
      out_err_code <= '0;
    end else begin
      out_cmd_valid <= 1'b0;
      out_err <= 1'b0;
      tmo <= (ps == S_HDR || out_rx_byte_valid) ? '0 : tmo + 1'b1;
      if (stop_err) begin
        out_err <= 1'b1;
        out_err_code <= ERR_STOP;
        ps <= S_HDR;
      end else if (out_rx_byte_valid) begin
        case (ps)
          S_HDR: if (out_rx_byte == FRAME_HDR) ps <= S_CMD;
          S_CMD: begin
            cmd_r <= out_rx_byte;
            ps <= S_PH;
          end
          S_PH: begin
            ph_r <= out_rx_byte;
            ps <= S_PL;
          end
          S_PL: begin
            pl_r <= out_rx_byte;
            ps <= S_SUM;
          end
          default: begin
            ps <= S_HDR;
            if (out_rx_byte == sum) begin
              out_cmd <= cmd_r;
              out_param <= {ph_r, pl_r};
              out_cmd_valid <= 1'b1;
            end else begin
              out_err <= 1'b1;
              out_err_code <= ERR_SUM;
            end
          end
        endcase
      end else if (tmo_hit) begin
        out_err <= 1'b1;
        out_err_code <= ERR_TMO;
        ps <= S_HDR;
      end
    end
  end
endmodule

// File: tb/tb_uart_recv_control.sv
// tb_uart_recv_control: directed frame, error, glitch and reset scenarios
module tb_uart_recv_control;
  localparam int BPS = 10;
  logic clk = 1'b0, rst_n = 1'b0, rxd = 1'b1;
  logic [7:0] rx_byte, cmd;
  logic [15:0] param;
  logic vld, cmdv, err, busy;
  logic [1:0] code;
  int cyc = 0, n_byte = 0, n_cmd = 0, n_err = 0, byte_cyc = 0, err_cyc = 0, fall_cyc = 0;
  logic [1:0] last_code = 2'b00;
  int checks = 0, errors = 0;
  int b0, c0, e0, bc, lat;
  uart_recv_control #(.CLK_FREQ(1000000), .UART_BPS(100000), .FRAME_HDR(8'hA5), .TIMEOUT_CLKS(500)) dut (
    .in_clk(clk),
    .in_rst(rst_n),
    .in_uart_rxd(rxd),
    .out_rx_byte(rx_byte),
    .out_rx_byte_valid(vld),
    .out_cmd(cmd),
    .out_param(param),
    .out_cmd_valid(cmdv),
    .out_err(err),
    .out_err_code(code),
    .out_busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (vld) begin
      n_byte <= n_byte + 1;
      byte_cyc <= cyc;
    end
    if (cmdv) n_cmd <= n_cmd + 1;
    if (err) begin
      n_err <= n_err + 1;
      err_cyc <= cyc;
      last_code <= code;
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    fall_cyc = cyc;
    rxd = 1'b0;
    repeat (BPS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BPS) @(negedge clk);
    end
    rxd = stop;
    repeat (BPS) @(negedge clk);
    rxd = 1'b1;
  endtask
  task automatic snap();
    b0 = n_byte;
    c0 = n_cmd;
    e0 = n_err;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("rst_byte", 32'(rx_byte), 0);
    check("rst_vld", 32'(vld), 0);
    check("rst_cmd", 32'(cmd), 0);
    check("rst_param", 32'(param), 0);
    check("rst_cmdv", 32'(cmdv), 0);
    check("rst_err", 32'(err), 0);
    check("rst_code", 32'(code), 0);
    check("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    snap();
    send_byte(8'hA5);
    lat = byte_cyc - fall_cyc;
    check("t1_latency", 32'(lat >= 97 && lat <= 100), 1);
    send_byte(8'h01);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h47);
    repeat (5) @(negedge clk);
    check("t1_nbyte", 32'(n_byte - b0), 5);
    check("t1_ncmd", 32'(n_cmd - c0), 1);
    check("t1_nerr", 32'(n_err - e0), 0);
    check("t1_cmd", 32'(cmd), 32'h01);
    check("t1_param", 32'(param), 32'h1234);
    check("t1_lastbyte", 32'(rx_byte), 32'h47);
    repeat (10) @(negedge clk);
    snap();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'hA5);
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h10);
    send_byte(8'h12);
    repeat (5) @(negedge clk);
    check("t2_nbyte", 32'(n_byte - b0), 8);
    check("t2_ncmd", 32'(n_cmd - c0), 0);
    check("t2_nerr", 32'(n_err - e0), 1);
    check("t2_code", 32'(last_code), 2);
    check("t2_cmd_hold", 32'(cmd), 32'h01);
    check("t2_param_hold", 32'(param), 32'h1234);
    repeat (600) @(negedge clk);
    check("t2_no_tmo", 32'(n_err - e0), 1);
    check("t2_code_hold", 32'(code), 2);
    check("t2_idle", 32'(busy), 0);
    snap();
    send_byte(8'hA5);
    send_byte(8'h03);
    bc = byte_cyc;
    repeat (600) @(negedge clk);
    check("t3_nerr", 32'(n_err - e0), 1);
    check("t3_code", 32'(last_code), 3);
    check("t3_tmo_gap", 32'((err_cyc - bc) >= 499 && (err_cyc - bc) <= 503), 1);
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'h05);
    send_byte(8'h08);
    repeat (5) @(negedge clk);
    check("t3_ncmd", 32'(n_cmd - c0), 1);
    check("t3_cmd", 32'(cmd), 32'h03);
    check("t3_param", 32'(param), 32'h0005);
    check("t3_nerr2", 32'(n_err - e0), 1);
    repeat (10) @(negedge clk);
    snap();
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    check("t4_busy_hi", 32'(busy), 1);
    rxd = 1'b1;
    repeat (6) @(negedge clk);
    check("t4_busy_lo", 32'(busy), 0);
    repeat (30) @(negedge clk);
    check("t4_nbyte", 32'(n_byte - b0), 0);
    check("t4_nerr", 32'(n_err - e0), 0);
    snap();
    send_byte(8'hA5);
    send_byte(8'h55, 1'b0);
    repeat (20) @(negedge clk);
    check("t5_nbyte", 32'(n_byte - b0), 1);
    check("t5_nerr", 32'(n_err - e0), 1);
    check("t5_code", 32'(last_code), 1);
    check("t5_parser_hdr", 32'(busy), 0);
    check("t5_byte_hold", 32'(rx_byte), 32'hA5);
    repeat (600) @(negedge clk);
    check("t5_no_tmo", 32'(n_err - e0), 1);
    send_byte(8'hA5);
    send_byte(8'h07);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_cmd", 32'(cmd), 0);
    check("t6_param", 32'(param), 0);
    check("t6_code", 32'(code), 0);
    check("t6_byte", 32'(rx_byte), 0);
    check("t6_busy", 32'(busy), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    snap();
    send_byte(8'h12);
    send_byte(8'h34);
    repeat (600) @(negedge clk);
    check("t6_ncmd", 32'(n_cmd - c0), 0);
    check("t6_nerr", 32'(n_err - e0), 0);
    check("t6_cmd_after", 32'(cmd), 0);
    check("t6_param_after", 32'(param), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
